// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: default sizing,
// FSM state encoding and ASCII constants used by the message requesters.
package uart_pkg;

  localparam int NREQ_DEFAULT   = 3;
  localparam int MAXLEN_DEFAULT = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle between the requesters / uart_tx on one side and the scheduler on
// the other. The slave side is the scheduler itself.
interface uart_tx_sched_if import uart_pkg::*; #(
  parameter int NREQ   = NREQ_DEFAULT,
  parameter int MAXLEN = MAXLEN_DEFAULT
);

  logic [NREQ-1:0]          req;
  logic [NREQ*8*MAXLEN-1:0] payload;
  logic [NREQ*4-1:0]        len;
  logic [NREQ-1:0]          done;
  logic                     busy;
  logic                     tx_start;
  logic [7:0]               tx_data;
  logic                     tx_busy;
  logic                     tx_done;

  modport master (
    output req, payload, len, tx_busy, tx_done,
    input  done, busy, tx_start, tx_data
  );

  modport slave (
    input  req, payload, len, tx_busy, tx_done,
    output done, busy, tx_start, tx_data
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick among pending channels; the search starts one past the
// channel granted last, so every pending channel is reached within NREQ picks.
module rr_arbiter import uart_pkg::*; #(
  parameter int NREQ = NREQ_DEFAULT,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   last_grant,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx
);

  // First pending channel found walking forward from last_grant+1.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant) + off) % NREQ;
      if (!grant_valid && pending[IW'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Serialises per-channel messages into single bytes for uart_tx. Requests are
// latched as pending flags, granted round-robin, and each granted message is
// copied into a shift register so requesters may change after LOAD.
module uart_tx_sched import uart_pkg::*; #(
  parameter int NREQ   = NREQ_DEFAULT,
  parameter int MAXLEN = MAXLEN_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  uart_tx_sched_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXLEN + 1);
  localparam int PW = 8 * MAXLEN;

  logic [2:0]      state;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] load_clr;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   ch;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic [3:0]      len_sel;
  logic [PW-1:0]   shift;
  logic [CW-1:0]   cnt;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic [NREQ-1:0] done_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Length of the channel being loaded and the pending bit it retires.
  always_comb begin
    len_sel  = bus.len[int'(ch)*4 +: 4];
    load_clr = '0;
    if (state == ST_LOAD) load_clr[ch] = 1'b1;
  end

  // Pending flags: a request in the LOAD cycle of its own channel survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    else     pending <= (pending & ~load_clr) | bus.req;
  end

  // Message FSM: grant, load, then one start/wait pair per byte, then done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= IW'(NREQ - 1);
      ch         <= '0;
      // NOTE: the shift register is plain flops, not a memory, so it is cleared with the rest.
      shift      <= '0;
      cnt        <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= '0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            ch         <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift <= bus.payload[int'(ch)*PW +: PW];
          cnt   <= (int'(len_sel) > MAXLEN) ? CW'(MAXLEN) : CW'(len_sel);
          state <= (len_sel == 4'd0) ? ST_FIN : ST_START;
        end
        ST_START: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= shift[7:0];
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.tx_done) begin
            shift <= shift >> 8;
            cnt   <= cnt - CW'(1);
            state <= (cnt == CW'(1)) ? ST_FIN : ST_START;
          end
        end
        ST_FIN: begin
          done_q[ch] <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a simple uart_tx frame model.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NREQ   = 3;
  localparam int MAXLEN = 8;
  localparam int PW     = 8 * MAXLEN;
  localparam int FRAME  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_sched_if #(.NREQ(NREQ), .MAXLEN(MAXLEN)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .MAXLEN(MAXLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  logic model_busy = 1'b0;
  logic model_done = 1'b0;
  logic ext_busy   = 1'b0;
  logic ext_done   = 1'b0;
  assign bus.tx_busy = model_busy | ext_busy;
  assign bus.tx_done = model_done | ext_done;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int cyc    = 0;
  int frame_cnt  = 0;
  int model_last = NREQ - 1;
  logic prev_start = 1'b0;

  logic [7:0] byte_q[$];
  int start_q[$];
  int done_ch_q[$];
  int done_cyc_q[$];
  int txd_q[$];

  typedef struct {
    int         ch;
    logic [3:0] len;
    logic [63:0] payload;
    int         exp_n;
  } vec_t;
  vec_t vecs[6];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // uart_tx stand-in: FRAME cycles busy per byte, done pulse as busy falls.
  initial forever begin
    @(posedge clk);
    #1;
    model_done = 1'b0;
    if (rst) begin
      frame_cnt  = 0;
      model_busy = 1'b0;
    end else if (frame_cnt > 0) begin
      frame_cnt--;
      if (frame_cnt == 0) begin
        model_busy = 1'b0;
        model_done = 1'b1;
      end
    end else if (bus.tx_start) begin
      model_busy = 1'b1;
      frame_cnt  = FRAME;
    end
  end

  // Event log and always-true properties, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.tx_start) begin
        byte_q.push_back(bus.tx_data);
        start_q.push_back(cyc);
        if (prev_start) begin
          viol++;
          $display("FAIL tx_start_back_to_back cycle=%0d", cyc);
        end
      end
      prev_start = bus.tx_start;
      if ($countones(bus.done) > 1) begin
        viol++;
        $display("FAIL done_onehot actual=%b cycle=%0d", bus.done, cyc);
      end
      for (int i = 0; i < NREQ; i++)
        if (bus.done[i]) begin
          done_ch_q.push_back(i);
          done_cyc_q.push_back(cyc);
        end
      if (bus.tx_done) txd_q.push_back(cyc);
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    byte_q.delete();
    start_q.delete();
    done_ch_q.delete();
    done_cyc_q.delete();
    txd_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    ext_busy = 1'b0;
    ext_done = 1'b0;
    repeat (3) tick();
    rst        = 1'b0;
    model_last = NREQ - 1;
    clear_logs();
  endtask

  // Drive a one-cycle request; e0 is the cycle number of the sampling edge.
  task automatic pulse_req(input logic [NREQ-1:0] mask, output int e0);
    bus.req = mask;
    e0      = cyc + 1;
    tick();
    bus.req = '0;
  endtask

  task automatic wait_quiet(input string name);
    int idle = 0;
    int n    = 0;
    while (idle < 8 && n < 4000) begin
      tick();
      n++;
      if (bus.busy || bus.req != '0) idle = 0;
      else idle++;
    end
    check({name, "_quiet"}, 64'(idle >= 8), 64'd1);
  endtask

  // Same-cycle request batch: every requested channel is served once, in
  // rotation order after the channel served last, each sending min(len,MAXLEN) bytes.
  task automatic run_batch(input string name, input logic [NREQ-1:0] mask);
    logic [7:0] eb[$];
    int ed[$];
    int e0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      int n;
      c = (model_last + k) % NREQ;
      if (mask[c]) begin
        n = int'(bus.len[c*4 +: 4]);
        if (n > MAXLEN) n = MAXLEN;
        for (int b = 0; b < n; b++) eb.push_back(bus.payload[c*PW + b*8 +: 8]);
        ed.push_back(c);
      end
    end
    clear_logs();
    pulse_req(mask, e0);
    wait_quiet(name);
    check({name, "_nbytes"}, 64'(byte_q.size()), 64'(eb.size()));
    for (int b = 0; b < eb.size() && b < byte_q.size(); b++)
      check($sformatf("%s_byte%0d", name, b), 64'(byte_q[b]), 64'(eb[b]));
    check({name, "_ndone"}, 64'(done_ch_q.size()), 64'(ed.size()));
    for (int d = 0; d < ed.size() && d < done_ch_q.size(); d++)
      check($sformatf("%s_done%0d_ch", name, d), 64'(done_ch_q[d]), 64'(ed[d]));
    if (ed.size() > 0) model_last = ed[ed.size()-1];
  endtask

  initial begin
    int e0;
    int n;
    logic [NREQ-1:0] m;

    vecs[0] = '{ch: 1, len: 4'd3,  payload: 64'h0000_0000_0032_3D54, exp_n: 3};
    vecs[1] = '{ch: 2, len: 4'd0,  payload: 64'hDEAD_BEEF_0000_0000, exp_n: 0};
    vecs[2] = '{ch: 0, len: 4'd15, payload: 64'h8877_6655_4433_2211, exp_n: 8};
    vecs[3] = '{ch: 1, len: 4'd8,  payload: 64'h0123_4567_89AB_CDEF, exp_n: 8};
    vecs[4] = '{ch: 2, len: 4'd2,  payload: {48'h0, LF, CR},          exp_n: 2};
    vecs[5] = '{ch: 0, len: 4'd9,  payload: 64'hF0E1_D2C3_B4A5_9687, exp_n: 8};

    bus.req     = '0;
    bus.payload = '0;
    bus.len     = '0;

    // Reset values while rst is held.
    repeat (3) tick();
    check("rst_busy",     64'(bus.busy),     64'd0);
    check("rst_tx_start", 64'(bus.tx_start), 64'd0);
    check("rst_tx_data",  64'(bus.tx_data),  64'd0);
    check("rst_done",     64'(bus.done),     64'd0);
    do_reset();

    // Stray tx_done while idle must not disturb anything.
    ext_done = 1'b1;
    tick();
    ext_done = 1'b0;
    tick();
    check("idle_txdone_busy", 64'(bus.busy), 64'd0);

    // Single-channel vectors.
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      bus.payload[vecs[i].ch*PW +: PW] = vecs[i].payload;
      bus.len[vecs[i].ch*4 +: 4]       = vecs[i].len;
      m = '0;
      m[vecs[i].ch] = 1'b1;
      pulse_req(m, e0);
      wait_quiet($sformatf("vec%0d", i));
      check($sformatf("vec%0d_nbytes", i), 64'(byte_q.size()), 64'(vecs[i].exp_n));
      for (int k = 0; k < vecs[i].exp_n && k < byte_q.size(); k++)
        check($sformatf("vec%0d_byte%0d", i, k), 64'(byte_q[k]), 64'(vecs[i].payload[8*k +: 8]));
      check($sformatf("vec%0d_ndone", i), 64'(done_ch_q.size()), 64'd1);
      if (done_ch_q.size() > 0) begin
        check($sformatf("vec%0d_done_ch", i), 64'(done_ch_q[0]), 64'(vecs[i].ch));
        if (vecs[i].exp_n == 0)
          check($sformatf("vec%0d_done_lat", i), 64'(done_cyc_q[0] - e0), 64'd3);
        else if (txd_q.size() > 0)
          // done follows one edge after the edge that samples the last tx_done
          check($sformatf("vec%0d_done_after_txdone", i),
                64'(done_cyc_q[0] - txd_q[txd_q.size()-1]), 64'd2);
      end
      if (vecs[i].exp_n > 0 && start_q.size() > 0)
        check($sformatf("vec%0d_start_lat", i), 64'(start_q[0] - e0), 64'd3);
      model_last = vecs[i].ch;
    end

    // All three at once, one byte each: served 0, 1, 2.
    do_reset();
    for (int c = 0; c < NREQ; c++) begin
      bus.len[c*4 +: 4]      = 4'd1;
      bus.payload[c*PW +: 8] = 8'(8'hA0 + c);
    end
    run_batch("all3", 3'b111);
    for (int d = 0; d < 3 && d < done_ch_q.size(); d++)
      check($sformatf("all3_order%0d", d), 64'(done_ch_q[d]), 64'(d));

    // ch0 and ch2 re-requested continuously: grants must alternate.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      bus.req = (i % 7 == 0) ? 3'b101 : 3'b000;
      tick();
    end
    bus.req = '0;
    wait_quiet("rr_fair");
    check("rr_fair_count", 64'(done_ch_q.size() >= 6), 64'd1);
    for (int j = 0; j < 6 && j < done_ch_q.size(); j++)
      check($sformatf("rr_fair_done%0d", j), 64'(done_ch_q[j]), 64'((j % 2 == 0) ? 0 : 2));

    // len=15 with tx_busy held for 5 cycles at START; stray tx_done in START.
    do_reset();
    bus.len[3:0]      = 4'd15;
    bus.payload[63:0] = 64'h1122_3344_5566_7788;
    ext_busy = 1'b1;
    pulse_req(3'b001, e0);
    repeat (2) tick();
    ext_done = 1'b1;
    tick();
    ext_done = 1'b0;
    repeat (4) tick();
    ext_busy = 1'b0;
    wait_quiet("hold");
    check("hold_nbytes", 64'(byte_q.size()), 64'd8);
    if (start_q.size() > 0) check("hold_start_cycle", 64'(start_q[0] - e0), 64'd8);
    if (byte_q.size() > 0)  check("hold_byte0", 64'(byte_q[0]), 64'h88);
    check("hold_ndone", 64'(done_ch_q.size()), 64'd1);

    // Reset after the 2nd tx_done of a 4-byte message.
    do_reset();
    bus.len[7:4]        = 4'd4;
    bus.payload[127:64] = 64'h0000_0000_4433_2211;
    pulse_req(3'b010, e0);
    n = 0;
    while (txd_q.size() < 2 && n < 500) begin
      tick();
      n++;
    end
    check("midrst_reached", 64'(txd_q.size() >= 2), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy",     64'(bus.busy),     64'd0);
    check("midrst_tx_start", 64'(bus.tx_start), 64'd0);
    check("midrst_tx_data",  64'(bus.tx_data),  64'd0);
    check("midrst_done",     64'(bus.done),     64'd0);
    repeat (3) tick();
    rst        = 1'b0;
    model_last = NREQ - 1;
    wait_quiet("midrst");
    check("midrst_nbytes", 64'(byte_q.size()), 64'd2);
    check("midrst_ndone",  64'(done_ch_q.size()), 64'd0);
    run_batch("after_rst", 3'b010);

    // Random same-cycle batches against the rotation model.
    do_reset();
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < NREQ; c++) begin
        bus.len[c*4 +: 4]       = 4'($urandom_range(0, 15));
        bus.payload[c*PW +: PW] = {$urandom, $urandom};
      end
      run_batch($sformatf("rnd%0d", r), 3'($urandom_range(1, 7)));
    end

    check("invariants", 64'(viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
